// File: rtl/wrapper_ahb_packet_builder_if.sv
// Bus bundle for the packet builder: AHB-Lite slave side plus the valid/ready packet stream.
interface wrapper_ahb_packet_builder_if #(
    parameter int ADDRWIDTH   = 11,
    parameter int PACKETWIDTH = 256
);
    logic                   hsels;
    logic [ADDRWIDTH-1:0]   haddrs;
    logic [1:0]             htranss;
    logic [2:0]             hsizes;
    logic                   hwrites;
    logic                   hreadys;
    logic [31:0]            hwdatas;
    logic                   hreadyouts;
    logic                   hresps;
    logic [31:0]            hrdatas;
    logic [PACKETWIDTH-1:0] packet_data;
    logic                   packet_data_last;
    logic                   packet_data_valid;
    logic                   packet_data_ready;

    modport slave (
        input  hsels, haddrs, htranss, hsizes, hwrites, hreadys, hwdatas, packet_data_ready,
        output hreadyouts, hresps, hrdatas, packet_data, packet_data_last, packet_data_valid
    );

    modport master (
        output hsels, haddrs, htranss, hsizes, hwrites, hreadys, hwdatas, packet_data_ready,
        input  hreadyouts, hresps, hrdatas, packet_data, packet_data_last, packet_data_valid
    );
endinterface

// File: rtl/wrapper_ahb_packet_builder.sv
// AHB-Lite write-assembly buffer that emits a packet when the top byte of the last word is written.
// Optional: define WRAPPER_PACKET_BUILDER_CLEAR_EN to zero the buffer on every emission.
module wrapper_ahb_packet_builder #(
    parameter int ADDRWIDTH   = 11,
    parameter int PACKETWIDTH = 256
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    wrapper_ahb_packet_builder_if.slave bus
);
    localparam int PBW   = $clog2(PACKETWIDTH / 8);
    localparam int WORDS = PACKETWIDTH / 32;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

`ifdef WRAPPER_PACKET_BUILDER_CLEAR_EN
    localparam bit CLEAR_ON_EMIT = 1'b1;
`else
    localparam bit CLEAR_ON_EMIT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WR, RD, WR_STALL} state_t;

    state_t                 state;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [2:0]             size_q;
    logic [31:0]            hold_q;
    logic [31:0]            buf_q    [WORDS];
    logic [31:0]            buf_next [WORDS];
    logic [PACKETWIDTH-1:0] flat_next;
    logic [3:0]             strb;
    logic [IW-1:0]          widx;
    logic [IW-1:0]          ridx;
    logic [31:0]            wdata;
    logic [31:0]            merged;
    logic                   completing;
    logic                   do_write;
    logic                   emit;
    logic                   accept;
    logic                   handshake;
    logic                   ready_out;
    logic                   unused_bits;

    function automatic logic [3:0] byte_strobes(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    byte_strobes = 4'b0001 << lsb;
            3'd1:    byte_strobes = lsb[1] ? 4'b1100 : 4'b0011;
            default: byte_strobes = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                                input logic [3:0] lanes);
        for (int b = 0; b < 4; b++) begin
            merge_bytes[8*b +: 8] = lanes[b] ? data[8*b +: 8] : old[8*b +: 8];
        end
    endfunction

    assign unused_bits = bus.htranss[0];
    assign widx        = (WORDS > 1) ? addr_q[IW+1:2] : '0;
    assign ridx        = (WORDS > 1) ? bus.haddrs[IW+1:2] : '0;
    assign strb        = byte_strobes(size_q, addr_q[1:0]);
    assign completing  = strb[3] && (widx == IW'(WORDS - 1));
    assign handshake   = bus.packet_data_valid && bus.packet_data_ready;
    assign accept      = bus.hsels && bus.hreadys && bus.htranss[1];

    // A completing write may only finish when the output slot can take the packet this edge.
    always_comb begin
        ready_out = 1'b1;
        if (state == WR_STALL) begin
            ready_out = bus.packet_data_ready;
        end else if ((state == WR) && completing && bus.packet_data_valid && !bus.packet_data_ready) begin
            ready_out = 1'b0;
        end
    end

    assign bus.hreadyouts = ready_out;
    assign bus.hresps     = 1'b0;

    assign do_write = ((state == WR) || (state == WR_STALL)) && ready_out;
    assign emit     = do_write && completing;
    assign wdata    = (state == WR_STALL) ? hold_q : bus.hwdatas;
    assign merged   = merge_bytes(buf_q[widx], wdata, strb);

    // The packet is taken from the merged buffer before any clear-on-emit.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            buf_next[i] = buf_q[i];
        end
        if (do_write) begin
            buf_next[widx] = merged;
        end
        for (int i = 0; i < WORDS; i++) begin
            flat_next[32*i +: 32] = buf_next[i];
        end
        if (emit && CLEAR_ON_EMIT) begin
            for (int i = 0; i < WORDS; i++) begin
                buf_next[i] = '0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state                 <= IDLE;
            addr_q                <= '0;
            size_q                <= '0;
            hold_q                <= '0;
            bus.hrdatas           <= '0;
            bus.packet_data       <= '0;
            bus.packet_data_last  <= 1'b0;
            bus.packet_data_valid <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                buf_q[i] <= buf_next[i];
            end
            if (emit) begin
                bus.packet_data       <= flat_next;
                bus.packet_data_valid <= 1'b1;
                bus.packet_data_last  <= &addr_q[ADDRWIDTH-1:PBW];
            end else if (handshake) begin
                bus.packet_data_valid <= 1'b0;
            end
            // Read data is registered from the post-write buffer so a read right after a write sees it.
            if (ready_out) begin
                if (accept) begin
                    state       <= bus.hwrites ? WR : RD;
                    addr_q      <= bus.haddrs;
                    size_q      <= bus.hsizes;
                    bus.hrdatas <= bus.hwrites ? '0 : buf_next[ridx];
                end else begin
                    state       <= IDLE;
                    bus.hrdatas <= '0;
                end
            end else if (state == WR) begin
                state  <= WR_STALL;
                hold_q <= bus.hwdatas;
            end
        end
    end
endmodule

// File: tb/tb_wrapper_ahb_packet_builder.sv
// Bench for wrapper_ahb_packet_builder: vector table plus stall and reset sequences, packet scoreboard.
module tb_wrapper_ahb_packet_builder;
    localparam int AW = 11;
    localparam int PW = 256;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    wrapper_ahb_packet_builder_if #(.ADDRWIDTH(AW), .PACKETWIDTH(PW)) bus ();

    wrapper_ahb_packet_builder #(.ADDRWIDTH(AW), .PACKETWIDTH(PW)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    assign bus.hreadys = bus.hreadyouts;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [PW-1:0] data;
        logic          last;
    } pkt_t;
    pkt_t sbq[$];

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [31:0]   data;
        logic [31:0]   exp_rd;
        bit            emits;
        logic [PW-1:0] exp_pkt;
        bit            exp_last;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every handshake pops one expected packet.
    always @(negedge hclk) begin
        pkt_t e;
        if (hresetn && bus.packet_data_valid && bus.packet_data_ready) begin
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_packet: got %0h expected none", bus.packet_data);
            end else begin
                e = sbq.pop_front();
                chk("packet_data", bus.packet_data, e.data);
                chk("packet_last", PW'(bus.packet_data_last), PW'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_bus();
        bus.hsels   = 1'b0;
        bus.htranss = 2'b00;
        bus.hwrites = 1'b0;
        bus.haddrs  = '0;
        bus.hsizes  = 3'd0;
    endtask

    task automatic addr_phase(input bit wr, input logic [AW-1:0] a, input logic [2:0] sz);
        bus.hsels   = 1'b1;
        bus.htranss = 2'b10;
        bus.hwrites = wr;
        bus.haddrs  = a;
        bus.hsizes  = sz;
        @(posedge hclk); #1;
        idle_bus();
    endtask

    task automatic finish_data(output int waits);
        waits = 0;
        while (!bus.hreadyouts && waits < 50) begin
            @(posedge hclk); #1;
            waits++;
        end
        @(posedge hclk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [2:0] sz, input logic [31:0] d,
                            output int waits);
        addr_phase(1'b1, a, sz);
        bus.hwdatas = d;
        finish_data(waits);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] rd, output int waits);
        addr_phase(1'b0, a, 3'd2);
        rd = bus.hrdatas;
        finish_data(waits);
    endtask

    task automatic add_vec(input bit wr, input logic [AW-1:0] a, input logic [2:0] sz,
                           input logic [31:0] d, input logic [31:0] exp_rd, input bit emits,
                           input logic [PW-1:0] pkt, input bit last);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = sz; v.data = d; v.exp_rd = exp_rd;
        v.emits = emits; v.exp_pkt = pkt; v.exp_last = last;
        tbl.push_back(v);
    endtask

    task automatic add_pkt(input logic [AW-1:0] base, input logic [31:0] mult, input bit last,
                           output logic [PW-1:0] pkt);
        for (int i = 0; i < 8; i++) pkt[32*i +: 32] = mult * (i + 1);
        for (int i = 0; i < 8; i++)
            add_vec(1'b1, base + AW'(4 * i), 3'd2, pkt[32*i +: 32], '0, (i == 7), pkt, last);
    endtask

    initial begin
        logic [PW-1:0] p1, pt, pa, pb, pc;
        logic [PW-1:0] p_ab;
        logic [31:0]   rd;
        logic [31:0]   exp_w1, exp_w7;
        int            waits;
        pkt_t          e;

        idle_bus();
        bus.hwdatas           = '0;
        bus.packet_data_ready = 1'b0;

        // Table: full packet, byte completion, halfword + readback, top/non-top slots.
        add_pkt(11'h000, 32'h1111_1111, 1'b0, p1);
`ifdef WRAPPER_PACKET_BUILDER_CLEAR_EN
        p_ab   = {8'hAB, 248'h0};
        exp_w1 = 32'hBEEF_0000;
        exp_w7 = 32'h0000_0000;
`else
        p_ab   = {8'hAB, p1[247:0]};
        exp_w1 = 32'hBEEF_2222;
        exp_w7 = 32'h1010_1010;
`endif
        add_vec(1'b1, 11'h01F, 3'd0, 32'hAB00_0000, '0, 1'b1, p_ab, 1'b0);
        add_vec(1'b1, 11'h006, 3'd1, 32'hBEEF_0000, '0, 1'b0, '0, 1'b0);
        add_vec(1'b0, 11'h004, 3'd2, '0, exp_w1, 1'b0, '0, 1'b0);
        add_pkt(11'h7E0, 32'h0101_0101, 1'b1, pt);
        add_pkt(11'h7C0, 32'h0202_0202, 1'b0, pt);
        add_vec(1'b0, 11'h01C, 3'd2, '0, exp_w7, 1'b0, '0, 1'b0);

        repeat (2) @(posedge hclk);
        #1;
        chk("rst_hreadyouts", PW'(bus.hreadyouts), PW'(1));
        chk("rst_hresps", PW'(bus.hresps), PW'(0));
        chk("rst_hrdatas", PW'(bus.hrdatas), PW'(0));
        chk("rst_valid", PW'(bus.packet_data_valid), PW'(0));
        chk("rst_last", PW'(bus.packet_data_last), PW'(0));
        chk("rst_packet", bus.packet_data, '0);
        hresetn = 1'b1;
        bus.packet_data_ready = 1'b1;
        @(posedge hclk); #1;

        foreach (tbl[k]) begin
            if (tbl[k].wr) begin
                if (tbl[k].emits) begin
                    e.data = tbl[k].exp_pkt;
                    e.last = tbl[k].exp_last;
                    sbq.push_back(e);
                end
                do_write(tbl[k].addr, tbl[k].size, tbl[k].data, waits);
                chk($sformatf("wr_waits[%0d]", k), PW'(waits), PW'(0));
                chk($sformatf("wr_valid[%0d]", k), PW'(bus.packet_data_valid), PW'(tbl[k].emits));
                if (tbl[k].emits) begin
                    @(posedge hclk); #1;
                    chk($sformatf("valid_one_cycle[%0d]", k), PW'(bus.packet_data_valid), PW'(0));
                end
            end else begin
                do_read(tbl[k].addr, rd, waits);
                chk($sformatf("rd_data[%0d]", k), PW'(rd), PW'(tbl[k].exp_rd));
                chk($sformatf("rd_waits[%0d]", k), PW'(waits), PW'(0));
                chk($sformatf("rd_no_emit[%0d]", k), PW'(bus.packet_data_valid), PW'(0));
            end
        end

        // Back-pressure: second completing write stalls until ready rises.
        bus.packet_data_ready = 1'b0;
        for (int i = 0; i < 8; i++) pa[32*i +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 8; i++) pb[32*i +: 32] = 32'hB000_0000 + 32'(i);
        e.data = pa; e.last = 1'b0; sbq.push_back(e);
        for (int i = 0; i < 8; i++) begin
            do_write(AW'(4 * i), 3'd2, pa[32*i +: 32], waits);
            chk("stall_a_waits", PW'(waits), PW'(0));
        end
        chk("stall_a_valid", PW'(bus.packet_data_valid), PW'(1));
        e.data = pb; e.last = 1'b0; sbq.push_back(e);
        for (int i = 0; i < 7; i++) do_write(AW'(4 * i), 3'd2, pb[32*i +: 32], waits);
        addr_phase(1'b1, 11'h01C, 3'd2);
        bus.hwdatas = pb[255:224];
        chk("stall_hready_first", PW'(bus.hreadyouts), PW'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge hclk); #1;
            bus.hwdatas = 32'hDEAD_BEEF;
            chk("stall_hready", PW'(bus.hreadyouts), PW'(0));
            chk("stall_valid", PW'(bus.packet_data_valid), PW'(1));
            chk("stall_packet_hold", bus.packet_data, pa);
        end
        bus.packet_data_ready = 1'b1;
        #1;
        chk("stall_release_hready", PW'(bus.hreadyouts), PW'(1));
        @(posedge hclk); #1;
        chk("reload_valid_kept", PW'(bus.packet_data_valid), PW'(1));
        bus.hwdatas = '0;
        @(posedge hclk); #1;
        chk("reload_valid_cleared", PW'(bus.packet_data_valid), PW'(0));

        // Asynchronous reset while a completing write is stalled.
        bus.packet_data_ready = 1'b0;
        for (int i = 0; i < 8; i++) pc[32*i +: 32] = 32'hC000_0000 + 32'(i);
        e.data = pc; e.last = 1'b0; sbq.push_back(e);
        for (int i = 0; i < 8; i++) do_write(AW'(4 * i), 3'd2, pc[32*i +: 32], waits);
        for (int i = 0; i < 7; i++) do_write(AW'(4 * i), 3'd2, 32'hD000_0000 + 32'(i), waits);
        addr_phase(1'b1, 11'h01C, 3'd2);
        bus.hwdatas = 32'hD000_0007;
        @(posedge hclk); #1;
        chk("pre_reset_stalled", PW'(bus.hreadyouts), PW'(0));
        #2;
        hresetn = 1'b0;
        #1;
        chk("async_rst_valid", PW'(bus.packet_data_valid), PW'(0));
        chk("async_rst_hready", PW'(bus.hreadyouts), PW'(1));
        chk("async_rst_packet", bus.packet_data, '0);
        sbq.delete();
        bus.hwdatas = '0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        bus.packet_data_ready = 1'b1;
        do_read(11'h000, rd, waits);
        chk("post_rst_word0", PW'(rd), PW'(0));
        do_read(11'h01C, rd, waits);
        chk("post_rst_word7", PW'(rd), PW'(0));
        chk("post_rst_no_emit", PW'(bus.packet_data_valid), PW'(0));

        repeat (2) @(posedge hclk);
        #1;
        chk("scoreboard_drained", PW'(sbq.size()), PW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wrapper_ahb_packet_builder.md
Name: wrapper_ahb_packet_builder

Overview:
- AHB-Lite slave that accepts CPU writes into a PACKETWIDTH-bit assembly buffer.
- When the most-significant byte of a packet slot is written, the buffer is emitted as one packet on a valid/ready output toward the accelerator input.
- Counterpart of the packet deconstructor, which serves accelerator output packets to AHB reads.
- Sits in the accelerator wrapper's input half of the address map.

Parameters:
- ADDRWIDTH, 11, AHB address bits decoded by this slave.
- PACKETWIDTH, 256, packet width in bits; power of two, minimum 32.
- Derived: PBW = $clog2(PACKETWIDTH/8) (byte offset bits); WORDS = PACKETWIDTH/32.

Ports:
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low
- hsels  in  1  slave select
- haddrs  in  ADDRWIDTH  address
- htranss  in  2  transfer type
- hsizes  in  3  transfer size
- hwrites  in  1  write/read
- hreadys  in  1  bus ready
- hwdatas  in  32  write data
- hreadyouts  out  1  slave ready
- hresps  out  1  response; always OKAY (0)
- hrdatas  out  32  read data
- packet_data  out  PACKETWIDTH  emitted packet
- packet_data_last  out  1  packet came from the top packet slot
- packet_data_valid  out  1  output valid
- packet_data_ready  in  1  output ready

Behaviour:
- Reset values: hreadyouts=1, hresps=0, hrdatas=0, packet_data=0, packet_data_last=0, packet_data_valid=0, assembly buffer=0, FSM=IDLE.
- Address phase is accepted when hsels & hreadys & htranss[1] (NONSEQ/SEQ). On acceptance, register haddrs, hwrites, hsizes.
- Byte strobes are derived from hsizes and address[1:0]:
  - byte: one lane.
  - half: lanes {1,0} or {3,2}, selected by address[1].
  - hsizes >= 2: all four lanes.
- Word index within the packet = address[PBW-1:2].
- FSM states:
  - IDLE: no data phase pending.
  - WR: write data phase.
  - RD: read data phase.
  - WR_STALL: write data phase held off.
- IDLE/WR/RD → WR or RD on an accepted address phase; → IDLE otherwise. Back-to-back transfers with no idle cycle are supported.
- WR data phase: strobed bytes of hwdatas merge into the selected buffer word.
  - The write is "completing" if the strobes include lane 3 and the word index is WORDS-1.
  - A non-completing write finishes zero-wait.
- Completing write:
  - Output slot empty, or handshake this cycle: hreadyouts=1. On the next edge, packet_data = merged buffer, packet_data_valid=1, packet_data_last = (address[ADDRWIDTH-1:PBW] all ones).
  - Output slot full and packet_data_ready=0: hreadyouts=0, FSM=WR_STALL, hwdatas sampled and held.
- WR_STALL: hreadyouts = packet_data_ready, combinationally. The merge and emit happen in the cycle ready is high; packet_data_valid stays high across the reload. No new address phase is accepted while stalled (hreadys is low).
- RD data phase: zero-wait; hrdatas = current buffer word at the index. Reads never stall and never emit.
- Output handshake: valid & ready on an edge with no reload clears packet_data_valid. packet_data and packet_data_last hold stable while valid & !ready.
- IDLE/BUSY transfers and hsels=0 cause no state change.
- Asynchronous reset mid-packet or mid-stall discards the buffer and any pending packet; outputs return to reset values immediately.

Optional Feature:
- WRAPPER_PACKET_BUILDER_CLEAR_EN defined: the assembly buffer zeroes on the same edge a packet is emitted. Partial packets therefore carry zeros in unwritten bytes.
- Undefined: the buffer retains its contents after emission. Unwritten bytes carry the previous packet's values, and readback shows the retained data.

Test Plan:
- Words 0..7 written with 0x11111111..0x88888888 at base 0x000, ready held 1 -> one packet 0x88888888_..._11111111, valid for 1 cycle, last=0, no wait states.
- Byte write 0xAB to addr 0x01F only, ready=1 -> packet byte 31=0xAB. Other bytes: 0 with CLEAR_EN defined; previous packet's data without it.
- Two full packets, ready=0 -> second completing write sees hreadyouts low. Raise ready after 5 cycles -> first packet handshakes, second loads the same cycle, valid never drops.
- Full packet at slot base 0x7E0 (ADDRWIDTH=11) -> last=1. Same packet at 0x7C0 -> last=0.
- Halfword write 0xBEEF to 0x006, then read 0x004 -> hrdatas upper half 0xBEEF, zero-wait, no emission.
- Assert hresetn low during WR_STALL -> valid=0 and hreadyouts=1 immediately; buffer reads 0 after release.
